// File: rtl/fwd_pkg.sv
// Shared types and constants for the EX-stage forwarding / load-use controller.
package fwd_pkg;

   localparam int unsigned ENTRY_REG_W = 5;

   localparam logic [1:0] FWD_REG = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   typedef struct packed {
      logic                   valid;
      logic [ENTRY_REG_W-1:0] rs1;
      logic [ENTRY_REG_W-1:0] rs2;
      logic [ENTRY_REG_W-1:0] rd;
      logic                   regwrite;
      logic                   memread;
   } pipe_entry_t;

   localparam pipe_entry_t BUBBLE = '0;

   // True when the entry will write back rs; x0 is never a forwarding source.
   function automatic logic writes_reg(pipe_entry_t e, logic [ENTRY_REG_W-1:0] rs);
      return e.valid && e.regwrite && (e.rd != '0) && (e.rd == rs);
   endfunction

endpackage

// File: rtl/forward_ctrl_if.sv
// ID-stage metadata in, operand selects and stall control out.
interface forward_ctrl_if #(
   parameter int unsigned REG_W = 5,
   parameter int unsigned CNT_W = 16
);
   logic             id_valid_i;
   logic [REG_W-1:0] id_rs1_i;
   logic [REG_W-1:0] id_rs2_i;
   logic [REG_W-1:0] id_rd_i;
   logic             id_regwrite_i;
   logic             id_memread_i;
   logic             flush_i;
   logic [1:0]       forward_a_o;
   logic [1:0]       forward_b_o;
   logic             stall_o;
   logic [CNT_W-1:0] stall_cnt_o;

   modport master (
      output id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
      input  forward_a_o, forward_b_o, stall_o, stall_cnt_o
   );

   modport slave (
      input  id_valid_i, id_rs1_i, id_rs2_i, id_rd_i, id_regwrite_i, id_memread_i, flush_i,
      output forward_a_o, forward_b_o, stall_o, stall_cnt_o
   );
endinterface

// File: rtl/fwd_select.sv
// Operand-source select for one EX source register; EXMEM beats MEMWB.
module fwd_select
   import fwd_pkg::*;
(
   input  logic [ENTRY_REG_W-1:0] rs,
   input  pipe_entry_t            exmem,
   input  pipe_entry_t            memwb,
   output logic [1:0]             sel
);

   always_comb begin
      sel = FWD_REG;
      if (writes_reg(exmem, rs)) begin
         sel = FWD_MEM;
      end else if (writes_reg(memwb, rs)) begin
         sel = FWD_WB;
      end
   end

   // Source fields and memread of the later stages carry no meaning here.
   logic unused_fields;
   assign unused_fields = ^{exmem.rs1, exmem.rs2, exmem.memread,
                            memwb.rs1, memwb.rs2, memwb.memread};

endmodule

// File: rtl/forward_ctrl.sv
// Tracks rd metadata through ID/EX, EX/MEM, MEM/WB; drives forwarding selects and load-use stall.
module forward_ctrl
   import fwd_pkg::*;
#(
   parameter int unsigned REG_W = ENTRY_REG_W,
   parameter int unsigned CNT_W = 16
) (
   input  logic           clk_i,
   input  logic           rst_i,
   forward_ctrl_if.slave  bus
);

   pipe_entry_t      idex;
   pipe_entry_t      exmem;
   pipe_entry_t      memwb;
   pipe_entry_t      id_entry;
   logic             stall;
   logic [CNT_W-1:0] stall_cnt;
   logic [REG_W-1:0] id_rs1;
   logic [REG_W-1:0] id_rs2;
   logic [REG_W-1:0] id_rd;

   assign id_rs1 = bus.id_rs1_i;
   assign id_rs2 = bus.id_rs2_i;
   assign id_rd  = bus.id_rd_i;

   // Load in EX whose result the ID instruction needs; a flush overrides it.
   always_comb begin
      stall = 1'b0;
      if (bus.id_valid_i && !bus.flush_i &&
          idex.valid && idex.memread && idex.regwrite && (idex.rd != '0) &&
          ((idex.rd == ENTRY_REG_W'(id_rs1)) || (idex.rd == ENTRY_REG_W'(id_rs2)))) begin
         stall = 1'b1;
      end
   end

   always_comb begin
      id_entry = BUBBLE;
      if (bus.id_valid_i && !bus.flush_i && !stall) begin
         id_entry.valid    = 1'b1;
         id_entry.rs1      = ENTRY_REG_W'(id_rs1);
         id_entry.rs2      = ENTRY_REG_W'(id_rs2);
         id_entry.rd       = ENTRY_REG_W'(id_rd);
         id_entry.regwrite = bus.id_regwrite_i;
         id_entry.memread  = bus.id_memread_i;
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         idex      <= BUBBLE;
         exmem     <= BUBBLE;
         memwb     <= BUBBLE;
         stall_cnt <= '0;
      end else begin
         idex  <= id_entry;
         exmem <= idex;
         memwb <= exmem;
         if (stall && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
         end
      end
   end

   fwd_select u_fwd_a (
      .rs    (idex.rs1),
      .exmem (exmem),
      .memwb (memwb),
      .sel   (bus.forward_a_o)
   );

   fwd_select u_fwd_b (
      .rs    (idex.rs2),
      .exmem (exmem),
      .memwb (memwb),
      .sel   (bus.forward_b_o)
   );

   assign bus.stall_o     = stall;
   assign bus.stall_cnt_o = stall_cnt;

endmodule

// File: tb/tb_forward_ctrl.sv
// Scoreboard bench for forward_ctrl: each issued instruction queues the selects expected in its EX cycle.
module tb_forward_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   forward_ctrl_if #(.REG_W(5), .CNT_W(16)) bus ();

   forward_ctrl #(.REG_W(5), .CNT_W(16)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   typedef struct {
      string      tag;
      logic [1:0] a;
      logic [1:0] b;
   } exp_t;

   exp_t sb[$];
   int   checks   = 0;
   int   failures = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic drive(input logic v, input int rs1, input int rs2, input int rd,
                        input logic rw, input logic mr, input logic fl);
      bus.id_valid_i    = v;
      bus.id_rs1_i      = 5'(rs1);
      bus.id_rs2_i      = 5'(rs2);
      bus.id_rd_i       = 5'(rd);
      bus.id_regwrite_i = rw;
      bus.id_memread_i  = mr;
      bus.flush_i       = fl;
   endtask

   // Present one ID instruction for a cycle; ea/eb are the selects expected when it sits in EX.
   task automatic step(input string tag, input logic v, input int rs1, input int rs2, input int rd,
                       input logic rw, input logic mr, input logic fl,
                       input logic exp_stall, input logic [1:0] ea, input logic [1:0] eb);
      exp_t e;
      drive(v, rs1, rs2, rd, rw, mr, fl);
      #2;
      check_eq({tag, "_stall"}, 32'(bus.stall_o), 32'(exp_stall));
      e.tag = tag;
      e.a   = ea;
      e.b   = eb;
      sb.push_back(e);
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check_eq({tag, "_sb_empty"}, 32'(1), 32'(0));
      end else begin
         e = sb.pop_front();
         check_eq({e.tag, "_fa"}, 32'(bus.forward_a_o), 32'(e.a));
         check_eq({e.tag, "_fb"}, 32'(bus.forward_b_o), 32'(e.b));
      end
   endtask

   initial begin
      rst = 1'b1;
      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("rst_fa",  32'(bus.forward_a_o), 32'(2'b00));
      check_eq("rst_fb",  32'(bus.forward_b_o), 32'(2'b00));
      check_eq("rst_stall", 32'(bus.stall_o), 32'(0));
      check_eq("rst_cnt", 32'(bus.stall_cnt_o), 32'(0));

      // back-to-back ALU dependency
      step("add_x5",   1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
      step("sub_x6",   1, 5, 7, 6, 1, 0, 0, 0, 2'b10, 2'b00);
      // distance-2 dependency
      step("add_x5b",  1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
      step("nop1",     0, 0, 0, 0, 0, 0, 0, 0, 2'b00, 2'b00);
      step("or_d2",    1, 1, 5, 8, 1, 0, 0, 0, 2'b00, 2'b01);
      // two writes to x5 in a row: the newer one in EXMEM wins
      step("add_x5c",  1, 1, 2, 5, 1, 0, 0, 0, 2'b00, 2'b00);
      step("add_x5d",  1, 3, 4, 5, 1, 0, 0, 0, 2'b00, 2'b00);
      step("or_prio",  1, 1, 5, 8, 1, 0, 0, 0, 2'b00, 2'b10);
      // x0 destination is never forwarded
      step("add_x0",   1, 1, 2, 0, 1, 0, 0, 0, 2'b00, 2'b00);
      step("use_x0a",  1, 0, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00);
      step("use_x0b",  1, 0, 0, 11, 1, 0, 0, 0, 2'b00, 2'b00);
      // load-use: one stall, bubble, then MEMWB forwarding on both operands
      step("lw_x9",    1, 1, 0, 9, 1, 1, 0, 0, 2'b00, 2'b00);
      check_eq("cnt_pre_stall", 32'(bus.stall_cnt_o), 32'(0));
      step("lu_stall", 1, 9, 9, 10, 1, 0, 0, 1, 2'b00, 2'b00);
      step("lu_retry", 1, 9, 9, 10, 1, 0, 0, 0, 2'b01, 2'b01);
      check_eq("cnt_after_lu", 32'(bus.stall_cnt_o), 32'(1));
      // flush beats a load-use stall
      step("lw_x12",   1, 1, 0, 12, 1, 1, 0, 0, 2'b00, 2'b00);
      step("flush_lu", 1, 12, 12, 13, 1, 0, 1, 0, 2'b00, 2'b00);
      check_eq("cnt_after_flush", 32'(bus.stall_cnt_o), 32'(1));
      step("after_fl", 1, 12, 0, 14, 1, 0, 0, 0, 2'b01, 2'b00);
      // reset with three writers in flight
      step("wr_x1",    1, 20, 21, 1, 1, 0, 0, 0, 2'b00, 2'b00);
      step("wr_x2",    1, 20, 21, 2, 1, 0, 0, 0, 2'b00, 2'b00);
      step("lw_x3",    1, 20, 0, 3, 1, 1, 0, 0, 2'b00, 2'b00);
      rst = 1'b1;
      drive(1'b1, 3, 2, 4, 1'b1, 1'b0, 1'b0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      check_eq("mid_rst_fa",    32'(bus.forward_a_o), 32'(2'b00));
      check_eq("mid_rst_fb",    32'(bus.forward_b_o), 32'(2'b00));
      check_eq("mid_rst_stall", 32'(bus.stall_o), 32'(0));
      check_eq("mid_rst_cnt",   32'(bus.stall_cnt_o), 32'(0));
      step("post_rst", 1, 3, 2, 4, 1, 0, 0, 0, 2'b00, 2'b00);

      drive(1'b0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
      check_eq("sb_drained", 32'(sb.size()), 32'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Hard stop in case the stimulus ever stalls on the clock.
   initial begin
      #100000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/forward_ctrl.md
# forward_ctrl

Forwarding and load-use hazard controller for the 5-stage pipelined CPU. It tracks destination-register metadata through the ID/EX, EX/MEM and MEM/WB stages and drives the 2-bit operand-source selects consumed by the two 32-bit 3-input EX-stage operand muxes (Forward A / Forward B). It also detects load-use hazards and requests a one-cycle stall with bubble insertion. It sits beside the pipeline registers; it does not carry data, only register indices and control bits.

## Interface
- `REG_W`, default 5: register index width.
- `CNT_W`, default 16: stall counter width.
- `clk_i`, in, 1: clock; all state updates on the rising edge.
- `rst_i`, in, 1: **synchronous, active-high reset.**
- `id_valid_i`, in, 1: an instruction is present in the ID stage.
- `id_rs1_i`, in, REG_W: ID-stage source register 1.
- `id_rs2_i`, in, REG_W: ID-stage source register 2.
- `id_rd_i`, in, REG_W: ID-stage destination register.
- `id_regwrite_i`, in, 1: ID-stage instruction writes `rd`.
- `id_memread_i`, in, 1: ID-stage instruction is a load.
- `flush_i`, in, 1: branch taken; discard the ID-stage instruction.
- `forward_a_o`, out, 2: select for EX operand A.
- `forward_b_o`, out, 2: select for EX operand B.
- `stall_o`, out, 1: hold PC and IF/ID; insert a bubble into ID/EX.
- `stall_cnt_o`, out, CNT_W: saturating count of stall cycles.

## Operation
- **Select encoding:**
  - 00: register-file value from ID/EX.
  - 01: MEM/WB write-back data.
  - 10: EX/MEM ALU result.
  - 11: never driven.
- **Internal entries:** three `pipe_entry_t` entries (IDEX, EXMEM, MEMWB), each holding {valid, rs1, rs2, rd, regwrite, memread}. The rs fields are used only in IDEX.
- **Advance every cycle:**
  - MEMWB ← EXMEM.
  - EXMEM ← IDEX.
  - IDEX ← ID inputs, or a bubble (all fields zero) when `stall_o`, `flush_i` or `!id_valid_i` is asserted.
- **Forward A (computed on IDEX.rs1):**
  - Output 10 if EXMEM is valid, has regwrite, EXMEM.rd ≠ 0 and EXMEM.rd == IDEX.rs1.
  - Otherwise output 01 under the same conditions applied to MEMWB.
  - Otherwise output 00.
  - EXMEM has priority over MEMWB, so the newest value wins.
- **Forward B:** identical logic on IDEX.rs2.
- **Register x0 is never forwarded.**
- **`stall_o`** asserts when all of the following hold:
  - `id_valid_i` is 1 and `flush_i` is 0;
  - IDEX is valid with memread and regwrite, and IDEX.rd ≠ 0;
  - IDEX.rd equals `id_rs1_i` or `id_rs2_i`.
- **Stall and flush in the same cycle:** the flush wins. `stall_o` is 0 and IDEX receives a bubble.
- **After a stall:** the held instruction is re-presented on the next cycle. The load is now in EXMEM, so no second stall occurs. The load reaches MEMWB one cycle later and forwarding then returns 01.
- **`stall_cnt_o`:** increments by 1 on each cycle `stall_o`=1 and saturates at all-ones.

## Timing
- `forward_a_o` and `forward_b_o` are combinational from registered entries only. They are stable for the whole cycle and glitch-free relative to the ID inputs.
- `stall_o` is combinational from the ID inputs and IDEX, with zero-cycle latency. The CPU samples it at the same edge.
- **Reset values:**
  - All entries are bubbles.
  - `forward_a_o` = `forward_b_o` = 00.
  - `stall_o` = 0 (because IDEX is invalid).
  - `stall_cnt_o` = 0.
- **Reset asserted mid-operation:** every in-flight entry is discarded on that edge. No forwarding occurs on the following cycle.
- A dependency on an instruction three or more stages back is not forwarded. The register file writes in the first half of the cycle.

## Structure
- **`fwd_pkg`** holds:
  - the `FWD_REG`, `FWD_WB` and `FWD_MEM` constants (2'b00, 2'b01, 2'b10);
  - the `pipe_entry_t` typedef;
  - the `BUBBLE` constant.
- **Sub-module `fwd_select`:** takes one rs plus the EXMEM and MEMWB entries and returns the 2-bit select. It is instantiated twice, once for operand A and once for operand B.

## Test plan
- **Back-to-back ALU dependency:** `add x5` followed by `sub x6,x5,x7` → `forward_a_o`=10 in the sub's EX cycle; `forward_b_o`=00.
- **Distance-2 dependency, double write:** `add x5`, nop, `or x8,x1,x5` → `forward_b_o`=01. The same test with two writes to x5 in a row must yield 10, checking EXMEM priority.
- **x0 destination:** `add x0,...` followed by a use of x0 → both selects stay 00.
- **Load-use:** `lw x9` followed by `add x10,x9,x9` → `stall_o`=1 for exactly one cycle and the bubble enters IDEX. On the next EX cycle both selects are 01 and `stall_cnt_o`=1.
- **Flush with stall condition:** `flush_i`=1 while a load-use condition is present → `stall_o`=0, IDEX receives a bubble and `stall_cnt_o` is unchanged.
- **Reset mid-operation:** assert `rst_i` for one cycle with three writers in flight → the next cycle shows selects 00, `stall_o`=0 and `stall_cnt_o`=0.
